// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer-memory datapath.
package cnn_pkg;

  localparam int NREQ_DEF = 3;
  localparam int AW_DEF   = 12;
  localparam int DW_DEF   = 20;
  localparam int SW_DEF   = 3;

  // Requester id width; must cover NREQ_DEF requesters.
  localparam int IDW = 2;

  localparam int REQ_CONV = 0;
  localparam int REQ_MAXP = 1;
  localparam int REQ_FLAT = 2;

  localparam logic [SW_DEF-1:0] SEL_NONE = 3'd0;
  localparam logic [SW_DEF-1:0] SEL_L0K0 = 3'd1;
  localparam logic [SW_DEF-1:0] SEL_L0K1 = 3'd2;
  localparam logic [SW_DEF-1:0] SEL_L1K0 = 3'd3;
  localparam logic [SW_DEF-1:0] SEL_L1K1 = 3'd4;
  localparam logic [SW_DEF-1:0] SEL_L2   = 3'd5;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] owner;
    logic           null_rd;
  } rret_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first asserted request at or above the pointer,
// wrapping; the pointer moves just past each winner.
module rr_arbiter
  import cnn_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_win,
  output logic            o_found
);

  logic [IDW-1:0] r_ptr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_gnt   = '0;
    o_win   = '0;
    o_found = 1'b0;
    // Grants are held off during reset so no requester sees a phantom handshake.
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!o_found && i_req[i] && i >= int'(r_ptr)) begin
          o_found  = 1'b1;
          o_gnt[i] = 1'b1;
          o_win    = IDW'(i);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!o_found && i_req[i] && i < int'(r_ptr)) begin
          o_found  = 1'b1;
          o_gnt[i] = 1'b1;
          o_win    = IDW'(i);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_found) begin
      r_ptr <= (int'(o_win) == NREQ - 1) ? '0 : o_win + 1'b1;
    end
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// Shares the single layer-memory port among the conv / max-pool / flatten
// engines with registered strobes and a fixed two-cycle read return.
module layer_mem_arbiter
  import cnn_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int SW   = SW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*SW-1:0] req_sel,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             crd,
  output logic [AW-1:0]    caddr_rd,
  output logic             cwr,
  output logic [AW-1:0]    caddr_wr,
  output logic [DW-1:0]    cdata_wr,
  input  logic [DW-1:0]    cdata_rd,
  output logic [SW-1:0]    csel
);

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_win;
  logic            w_found;
  logic            w_we;
  logic [SW-1:0]   w_sel;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_null;

  logic            r_crd;
  logic            r_cwr;
  logic [AW-1:0]   r_caddr_rd;
  logic [AW-1:0]   r_caddr_wr;
  logic [DW-1:0]   r_cdata_wr;
  logic [SW-1:0]   r_csel;
  rret_t           r_p0;
  rret_t           r_p1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  (req),
    .o_gnt  (w_gnt),
    .o_win  (w_win),
    .o_found(w_found)
  );

  assign gnt = w_gnt;

  always_comb begin
    w_we    = 1'b0;
    w_sel   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_we    = req_we[i];
        w_sel   = req_sel[i*SW +: SW];
        w_addr  = req_addr[i*AW +: AW];
        w_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // A select of zero is a null access: handshaken, but never strobed.
  assign w_null = (w_sel == SEL_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_csel     <= '0;
      r_p0       <= '0;
      r_p1       <= '0;
    end else begin
      r_crd <= w_found && !w_we && !w_null;
      r_cwr <= w_found &&  w_we && !w_null;
      if (w_found) begin
        r_csel <= w_sel;
        if (w_we) begin
          r_caddr_wr <= w_addr;
          r_cdata_wr <= w_wdata;
        end else begin
          r_caddr_rd <= w_addr;
        end
      end
      // Stage 0 lines up with the strobe, stage 1 with cdata_rd.
      r_p0 <= '{valid: w_found && !w_we, owner: w_win, null_rd: w_null};
      r_p1 <= r_p0;
    end
  end

  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = r_p1.valid && (r_p1.owner == IDW'(i));
    end
  end

  assign rdata = r_p1.null_rd ? '0 : cdata_rd;

endmodule
